// File: rtl/seg7_pkg.sv
// Shared types, constants and the digit-to-segment decode for the
// four-digit multiplexed 7-segment display path.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_e;

    localparam int NDIG = 4;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low segments, MSB is segment a and LSB is segment g.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] segs;
        case (digit)
            4'd0:    segs = 7'b0000001;
            4'd1:    segs = 7'b1001111;
            4'd2:    segs = 7'b0010010;
            4'd3:    segs = 7'b0000110;
            4'd4:    segs = 7'b1001100;
            4'd5:    segs = 7'b0100100;
            4'd6:    segs = 7'b0100000;
            4'd7:    segs = 7'b0001111;
            4'd8:    segs = 7'b0000000;
            4'd9:    segs = 7'b0000100;
            default: segs = SEG_BLANK;
        endcase
        return segs;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: one input bit per cycle, with a
// small IDLE/SHIFT/COMMIT sequencer wrapped around the datapath.
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int N = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [N-1:0] bin_i,
    output logic         ready_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         last_o,
    output logic [15:0]  bcdNext_o
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    state_e         state_q, state_d;
    logic [N-1:0]   bin_q, bin_d;
    logic [15:0]    acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [15:0]    adjAcc;
    logic [15:0]    shiftAcc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Add-3 correction on every nibble, then shift the next binary bit in.
    always_comb begin
        adjAcc = acc_q;
        for (int i = 0; i < NDIG; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                adjAcc[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
        shiftAcc = {adjAcc[14:0], bin_q[N-1]};
    end

    assign bcdNext_o = shiftAcc;

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ready_o = 1'b0;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        last_o  = 1'b0;
        case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                if (start_i) begin
                    state_d = SHIFT;
                    bin_d   = bin_i;
                    acc_d   = '0;
                    cnt_d   = CNT_LAST;
                end
            end
            SHIFT: begin
                busy_o = 1'b1;
                acc_d  = shiftAcc;
                bin_d  = bin_q << 1;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    last_o  = 1'b1;
                    cnt_d   = cnt_q;
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                busy_o  = 1'b1;
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit 7-segment controller: binary value in, BCD conversion, atomic
// digit commit and time-multiplexed scanning with leading-zero blanking.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int N        = 10,
    parameter int SCAN_DIV = 50000,
    parameter int BLANK_LZ = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         busy,
    output logic         done,
    output logic [15:0]  bcd_out,
    output logic [0:6]   seg,
    output logic [3:0]   dig_en_n
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

    logic           convLast;
    logic [15:0]    convBcd;

    logic [15:0]    digits_q, digits_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [1:0]     idx_q, idx_d;
    logic [6:0]     seg_q, seg_d;
    logic [3:0]     digEn_q, digEn_d;
    logic           tick;
    logic [3:0]     blank;
    logic [3:0]     curDigit;

    bin2bcd_seq #(
        .N(N)
    ) u_conv (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (in_valid),
        .bin_i    (in_data),
        .ready_o  (in_ready),
        .busy_o   (busy),
        .done_o   (done),
        .last_o   (convLast),
        .bcdNext_o(convBcd)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digits_q <= '0;
            presc_q  <= '0;
            idx_q    <= '0;
            seg_q    <= SEG_BLANK;
            digEn_q  <= 4'b1111;
        end else begin
            digits_q <= digits_d;
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            seg_q    <= seg_d;
            digEn_q  <= digEn_d;
        end
    end

    // Digits land on the same edge the converter finishes, so they are stable
    // for the whole COMMIT cycle and the segment update at its end.
    always_comb begin
        digits_d = convLast ? convBcd : digits_q;
        tick     = (presc_q == PRESC_LAST);
        presc_d  = tick ? '0 : presc_q + 1'b1;
        idx_d    = tick ? idx_q + 2'd1 : idx_q;
    end

    // Segments are registered from the next index so enables and pattern move together.
    always_comb begin
        blank[3] = (BLANK_LZ != 0) && (digits_q[15:12] == 4'd0);
        blank[2] = blank[3] && (digits_q[11:8] == 4'd0);
        blank[1] = blank[2] && (digits_q[7:4] == 4'd0);
        blank[0] = 1'b0;
        curDigit = digits_q[{idx_d, 2'b00} +: 4];
        seg_d    = blank[idx_d] ? SEG_BLANK : seg_decode(curDigit);
        digEn_d  = ~(4'b0001 << idx_d);
    end

    assign bcd_out  = digits_q;
    assign seg      = seg_q;
    assign dig_en_n = digEn_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: two instances with different scan
// rates and blanking modes, compared every cycle against a decimal-level model.
module tb_seg7_scan_ctrl;

    localparam int N     = 10;
    localparam int DIV_A = 2;
    localparam int DIV_B = 3;

    localparam logic [6:0] SEG_TABLE [10] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [N-1:0] in_data;

    logic         readyA, busyA, doneA;
    logic [15:0]  bcdA;
    logic [0:6]   segA;
    logic [3:0]   enA;
    logic         readyB, busyB, doneB;
    logic [15:0]  bcdB;
    logic [0:6]   segB;
    logic [3:0]   enB;

    int cmpCnt  = 0;
    int failCnt = 0;

    int edgeNo;
    int e0;
    int acceptVal;
    int comVal;
    int dispVal;
    bit inReset;
    bit acceptedLast;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(.N(N), .SCAN_DIV(DIV_A), .BLANK_LZ(1)) dutA (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(readyA),
        .in_data(in_data), .busy(busyA), .done(doneA), .bcd_out(bcdA),
        .seg(segA), .dig_en_n(enA)
    );

    seg7_scan_ctrl #(.N(N), .SCAN_DIV(DIV_B), .BLANK_LZ(0)) dutB (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(readyB),
        .in_data(in_data), .busy(busyB), .done(doneB), .bcd_out(bcdB),
        .seg(segB), .dig_en_n(enB)
    );

    function automatic logic [15:0] toBcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] expSeg(input int v, input int k, input int div, input bit blankLz);
        int pw [4];
        int idx;
        pw  = '{1, 10, 100, 1000};
        idx = (k / div) % 4;
        if (blankLz && idx > 0 && v < pw[idx]) return 7'b1111111;
        return SEG_TABLE[(v / pw[idx]) % 10];
    endfunction

    function automatic logic [3:0] expEn(input int k, input int div);
        int idx;
        idx = (k / div) % 4;
        return ~(4'b0001 << idx);
    endfunction

    function automatic bit modelBusy();
        return (e0 <= edgeNo) && (edgeNo <= e0 + N);
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        cmpCnt++;
        assert (obs === exp) else begin
            failCnt++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit valid, input logic [N-1:0] data);
        in_valid = valid;
        in_data  = data;
    endtask

    task automatic runCycle();
        bit acc;
        bit bsy;
        acc = rst_n && in_valid && !modelBusy();
        @(posedge clk);
        if (!rst_n) begin
            edgeNo       = 0;
            inReset      = 1'b1;
            e0           = -100;
            comVal       = 0;
            dispVal      = 0;
            acceptedLast = 1'b0;
        end else begin
            edgeNo++;
            inReset = 1'b0;
            if (edgeNo == e0 + N)     comVal  = acceptVal;
            if (edgeNo == e0 + N + 1) dispVal = acceptVal;
            if (acc) begin
                e0        = edgeNo;
                acceptVal = int'(in_data);
            end
            acceptedLast = acc;
        end
        @(negedge clk);
        bsy = modelBusy();
        checkOutput("A.in_ready", {15'd0, readyA}, {15'd0, !bsy});
        checkOutput("A.busy",     {15'd0, busyA},  {15'd0, bsy});
        checkOutput("A.done",     {15'd0, doneA},  {15'd0, edgeNo == e0 + N});
        checkOutput("A.bcd_out",  bcdA, toBcd(comVal));
        checkOutput("B.done",     {15'd0, doneB},  {15'd0, edgeNo == e0 + N});
        checkOutput("B.bcd_out",  bcdB, toBcd(comVal));
        if (inReset) begin
            checkOutput("A.seg_rst", {9'd0, segA}, 16'h007F);
            checkOutput("A.en_rst",  {12'd0, enA}, 16'h000F);
            checkOutput("B.seg_rst", {9'd0, segB}, 16'h007F);
            checkOutput("B.en_rst",  {12'd0, enB}, 16'h000F);
        end else begin
            checkOutput("A.seg", {9'd0, segA}, {9'd0, expSeg(dispVal, edgeNo, DIV_A, 1'b1)});
            checkOutput("A.en",  {12'd0, enA}, {12'd0, expEn(edgeNo, DIV_A)});
            checkOutput("B.seg", {9'd0, segB}, {9'd0, expSeg(dispVal, edgeNo, DIV_B, 1'b0)});
            checkOutput("B.en",  {12'd0, enB}, {12'd0, expEn(edgeNo, DIV_B)});
        end
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) runCycle();
    endtask

    // Present a value and keep in_valid up until the model says it was taken.
    task automatic loadValue(input logic [N-1:0] v);
        int waited;
        applyStimulus(1'b1, v);
        waited = 0;
        do begin
            runCycle();
            waited++;
        end while (!acceptedLast && waited < 40);
        if (!acceptedLast) begin
            cmpCnt++;
            failCnt++;
            $error("[TB] FAIL accept_timeout: observed waited=%0d required accept", waited);
        end
        applyStimulus(1'b0, v);
    endtask

    initial begin
        logic [N-1:0] edgeVals [8];
        logic [N-1:0] rv;
        edgeVals = '{10'd0, 10'd9, 10'd10, 10'd99, 10'd100, 10'd999, 10'd1000, 10'd1023};

        edgeNo = 0; e0 = -100; acceptVal = 0; comVal = 0; dispVal = 0;
        inReset = 1'b1; acceptedLast = 1'b0;
        rst_n = 1'b0;
        applyStimulus(1'b0, '0);
        runCycles(2);
        rst_n = 1'b1;
        runCycles(12);

        loadValue(10'd1023);
        runCycles(20);

        loadValue(10'd7);
        runCycles(20);

        applyStimulus(1'b1, 10'd5);
        runCycle();
        applyStimulus(1'b1, 10'd512);
        loadValue(10'd512);
        runCycles(20);

        loadValue(10'd999);
        runCycles(3);
        rst_n = 1'b0;
        runCycle();
        rst_n = 1'b1;
        runCycles(20);

        for (int i = 0; i < 8; i++) begin
            loadValue(edgeVals[i]);
            runCycles(16);
        end

        for (int i = 0; i < 25; i++) begin
            rv = N'($urandom_range(0, 1023));
            loadValue(rv);
            if ($urandom_range(0, 1) == 1) begin
                for (int j = 0; j < 4; j++) begin
                    applyStimulus(1'b1, N'($urandom));
                    runCycle();
                end
                applyStimulus(1'b0, in_data);
            end
            runCycles($urandom_range(0, 14));
        end
        runCycles(16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, failCnt);
        $finish;
    end

endmodule
